// File: rtl/c_demux_split5_5b.sv
// c_demux_split5_5b: one-deep request buffer that dispatches to five busy-tracked channels
module c_demux_split5_5b #(
   parameter int W_DATA = 5
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_drive,
   input  logic [W_DATA-1:0] i_data,
   input  logic [2:0]        i_sel,
   output logic              o_free,
   output logic              o_drive0,
   output logic              o_drive1,
   output logic              o_drive2,
   output logic              o_drive3,
   output logic              o_drive4,
   output logic [W_DATA-1:0] o_data0,
   output logic [W_DATA-1:0] o_data1,
   output logic [W_DATA-1:0] o_data2,
   output logic [W_DATA-1:0] o_data3,
   output logic [W_DATA-1:0] o_data4,
   input  logic              i_free0,
   input  logic              i_free1,
   input  logic              i_free2,
   input  logic              i_free3,
   input  logic              i_free4,
   output logic [4:0]        o_busy,
   output logic [7:0]        o_err_cnt
);
   typedef enum logic {IDLE, PEND} state_t;
   state_t            state;
   logic [W_DATA-1:0] hold_data;
   logic [2:0]        hold_sel;
   logic [4:0]        drive_q, free_vec, set_vec;
   logic [W_DATA-1:0] data_q [5];
   logic [7:0]        sel_oh;
   logic              pend, bad_sel, disp;
   logic [1:0]        err_inc;
   logic [8:0]        err_sum;
   assign free_vec = {i_free4, i_free3, i_free2, i_free1, i_free0};
   assign {o_drive4, o_drive3, o_drive2, o_drive1, o_drive0} = drive_q;
   assign o_data0 = data_q[0];
   assign o_data1 = data_q[1];
   assign o_data2 = data_q[2];
   assign o_data3 = data_q[3];
   assign o_data4 = data_q[4];
   // decode the held request against the channel occupancy seen at this edge (no free bypass)
   always_comb begin
      pend    = state == PEND;
      sel_oh  = 8'd1 << hold_sel;
      bad_sel = hold_sel > 3'd4;
      disp    = pend && !bad_sel && !(|(sel_oh[4:0] & o_busy));
      set_vec = disp ? sel_oh[4:0] : 5'd0;
      err_inc = 2'(pend && i_drive) + 2'(pend && bad_sel);
      err_sum = 9'(o_err_cnt) + 9'(err_inc);
   end
   // request FSM, channel busy flags, payload registers and saturating error counter
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         hold_data <= '0;
         hold_sel  <= '0;
         o_free    <= 1'b0;
         drive_q   <= '0;
         o_busy    <= '0;
         o_err_cnt <= '0;
         for (int n = 0; n < 5; n++) data_q[n] <= '0;
      end else begin
         o_free    <= pend && (bad_sel || disp);
         drive_q   <= set_vec;
         o_busy    <= (o_busy & ~free_vec) | set_vec;
         o_err_cnt <= err_sum > 9'd255 ? 8'd255 : err_sum[7:0];
         if (!pend && i_drive) begin
            hold_data <= i_data;
            hold_sel  <= i_sel;
            state     <= PEND;
         end
         if (pend && (bad_sel || disp)) state <= IDLE;
         for (int n = 0; n < 5; n++) if (set_vec[n]) data_q[n] <= hold_data;
      end
   end
endmodule

// File: tb/tb_c_demux_split5_5b.sv
// tb_c_demux_split5_5b: directed and randomized checks against a transaction-level reference model
module tb_c_demux_split5_5b;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       i_drive = 1'b0;
   logic [4:0] i_data = '0;
   logic [2:0] i_sel = '0;
   logic [4:0] i_free = '0;
   logic       o_free;
   logic       o_drive0, o_drive1, o_drive2, o_drive3, o_drive4;
   logic [4:0] od [5];
   logic [4:0] o_busy;
   logic [7:0] o_err_cnt;
   logic [4:0] drv;
   int         checks = 0;
   int         errors = 0;
   bit         chk_en = 1'b0;
   bit         m_pend;
   int         m_sel, m_data, m_err;
   logic [4:0] m_busy, e_drv;
   int         m_dat [5];
   bit         e_free;

   always #5 clk = ~clk;

   assign drv = {o_drive4, o_drive3, o_drive2, o_drive1, o_drive0};

   c_demux_split5_5b #(.W_DATA(5)) dut (
      .clk(clk), .rst(rst), .i_drive(i_drive), .i_data(i_data), .i_sel(i_sel),
      .o_free(o_free),
      .o_drive0(o_drive0), .o_drive1(o_drive1), .o_drive2(o_drive2), .o_drive3(o_drive3), .o_drive4(o_drive4),
      .o_data0(od[0]), .o_data1(od[1]), .o_data2(od[2]), .o_data3(od[3]), .o_data4(od[4]),
      .i_free0(i_free[0]), .i_free1(i_free[1]), .i_free2(i_free[2]), .i_free3(i_free[3]), .i_free4(i_free[4]),
      .o_busy(o_busy), .o_err_cnt(o_err_cnt)
   );

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s got=%0d expected=%0d at %0t", name, act, exp, $time);
      end
   endtask

   // reference: one held request, per-channel occupancy, errors counted and clamped at 255
   always @(posedge clk) begin
      int         inc;
      logic [4:0] nb;
      if (rst) begin
         m_pend = 0; m_sel = 0; m_data = 0; m_err = 0; m_busy = '0; e_free = 0; e_drv = '0;
         for (int n = 0; n < 5; n++) m_dat[n] = 0;
      end else begin
         inc = 0; e_free = 0; e_drv = '0;
         nb = m_busy & ~i_free;
         if (m_pend) begin
            if (i_drive) inc++;
            if (m_sel > 4) begin
               e_free = 1; inc++; m_pend = 0;
            end else if (!m_busy[m_sel]) begin
               e_free = 1; e_drv[m_sel] = 1'b1; m_dat[m_sel] = m_data; nb[m_sel] = 1'b1; m_pend = 0;
            end
         end else if (i_drive) begin
            m_pend = 1; m_sel = int'(i_sel); m_data = int'(i_data);
         end
         m_busy = nb;
         m_err = (m_err + inc > 255) ? 255 : m_err + inc;
      end
   end

   // every-cycle comparison of all outputs against the reference
   always @(negedge clk) if (chk_en) begin
      check("m_free", int'(o_free), int'(e_free));
      check("m_drive", int'(drv), int'(e_drv));
      check("m_busy", int'(o_busy), int'(m_busy));
      check("m_err", int'(o_err_cnt), m_err);
      for (int n = 0; n < 5; n++) check("m_data", int'(od[n]), m_dat[n]);
   end

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic req(input int sel, input int data);
      i_drive = 1'b1; i_sel = 3'(sel); i_data = 5'(data);
      @(negedge clk);
      i_drive = 1'b0;
   endtask

   task automatic pulse_free(input logic [4:0] v);
      i_free = v;
      @(negedge clk);
      i_free = '0;
   endtask

   initial begin
      @(negedge clk);
      chk_en = 1'b1;
      cyc(1);
      rst = 1'b0;
      check("rst_busy", int'(o_busy), 0);
      check("rst_err", int'(o_err_cnt), 0);
      check("rst_free", int'(o_free), 0);
      // basic dispatch, two-cycle latency
      req(2, 'h15);
      check("lat_t1_free", int'(o_free), 0);
      cyc(1);
      check("d2_drive", int'(drv), 5'b00100);
      check("d2_free", int'(o_free), 1);
      check("d2_data", int'(od[2]), 'h15);
      check("d2_busy", int'(o_busy), 5'b00100);
      // blocked request waits for channel release
      req(2, 'h0A);
      for (int k = 1; k <= 4; k++) begin
         check("blk_free", int'(o_free), 0);
         cyc(1);
      end
      pulse_free(5'b00100);
      check("blk_busy_clr", int'(o_busy), 0);
      check("blk_no_bypass", int'(o_free), 0);
      cyc(1);
      check("blk_drive", int'(drv), 5'b00100);
      check("blk_free_t7", int'(o_free), 1);
      check("blk_busy", int'(o_busy), 5'b00100);
      check("blk_data", int'(od[2]), 'h0A);
      // invalid destination
      pulse_free(5'b00100);
      req(6, 'h03);
      cyc(1);
      check("inv_free", int'(o_free), 1);
      check("inv_drive", int'(drv), 0);
      check("inv_err", int'(o_err_cnt), 1);
      check("inv_data2", int'(od[2]), 'h0A);
      // fill all five channels
      for (int n = 0; n < 5; n++) begin
         int k = 0;
         req(n, 17 + n);
         while (!o_free && k < 10) begin
            cyc(1);
            k++;
         end
         check("fill_free_wait", int'(o_free), 1);
      end
      check("fill_busy", int'(o_busy), 5'b11111);
      for (int n = 0; n < 5; n++) check("fill_data", int'(od[n]), 17 + n);
      // reset while a request is held
      pulse_free(5'b11111);
      req(1, 9);
      rst = 1'b1;
      cyc(1);
      rst = 1'b0;
      check("rp_busy", int'(o_busy), 0);
      check("rp_err", int'(o_err_cnt), 0);
      check("rp_free", int'(o_free), 0);
      check("rp_drive", int'(drv), 0);
      for (int n = 0; n < 5; n++) check("rp_data", int'(od[n]), 0);
      for (int k = 0; k < 4; k++) begin
         cyc(1);
         check("rp_no_free", int'(o_free), 0);
      end
      // error counter saturation
      for (int k = 0; k < 300; k++) begin
         req(5 + k % 3, k);
         cyc(1);
      end
      check("sat_err", int'(o_err_cnt), 255);
      pulse_free(5'b01000);
      cyc(1);
      check("stray_busy", int'(o_busy), 0);
      check("stray_err", int'(o_err_cnt), 255);
      check("stray_free", int'(o_free), 0);
      check("stray_drive", int'(drv), 0);
      // randomized traffic including protocol violations and resets
      rst = 1'b1;
      cyc(1);
      rst = 1'b0;
      for (int k = 0; k < 3000; k++) begin
         i_drive = ($urandom % 4) == 0;
         i_sel   = 3'($urandom_range(0, 7));
         i_data  = 5'($urandom);
         for (int j = 0; j < 5; j++) i_free[j] = ($urandom % 8) == 0;
         rst     = ($urandom % 200) == 0;
         @(negedge clk);
      end
      i_drive = 1'b0; i_free = '0; rst = 1'b0;
      cyc(2);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
